// File: rtl/axis_channel_packer.sv
// rtl/axis_channel_packer.sv - packs two half-width AXI-Stream channels into one full-width stream
// Each channel has its own FIFO; both heads are popped together so the i-th A pairs with the i-th B.
module axis_channel_packer #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          clear,
  input  logic                          swap,
  input  logic [AXIS_TDATA_WIDTH/2-1:0] S_AXIS_A_tdata,
  input  logic                          S_AXIS_A_tvalid,
  output logic                          S_AXIS_A_tready,
  input  logic [AXIS_TDATA_WIDTH/2-1:0] S_AXIS_B_tdata,
  input  logic                          S_AXIS_B_tvalid,
  output logic                          S_AXIS_B_tready,
  input  logic                          M_AXIS_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]   M_AXIS_tdata,
  output logic                          M_AXIS_tvalid,
  output logic                          skew_error
);
  localparam int HW = AXIS_TDATA_WIDTH / 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [HW-1:0] mem_a [FIFO_DEPTH];
  logic [HW-1:0] mem_b [FIFO_DEPTH];
  logic [AW-1:0] wr_a, rd_a, wr_b, rd_b;
  logic [CW-1:0] cnt_a, cnt_b;
  logic          full_a, full_b, empty_a, empty_b;
  logic          push_a, push_b, out_free, pop;
  logic [HW-1:0] head_a, head_b;

  assign full_a  = (cnt_a == FULL_CNT);
  assign full_b  = (cnt_b == FULL_CNT);
  assign empty_a = (cnt_a == '0);
  assign empty_b = (cnt_b == '0);

  // Ready depends only on registered occupancy, never on downstream ready.
  assign S_AXIS_A_tready = aresetn && !full_a;
  assign S_AXIS_B_tready = aresetn && !full_b;

  assign push_a   = S_AXIS_A_tvalid && S_AXIS_A_tready;
  assign push_b   = S_AXIS_B_tvalid && S_AXIS_B_tready;
  assign out_free = !M_AXIS_tvalid || M_AXIS_tready;
  assign pop      = !empty_a && !empty_b && out_free;

  assign head_a = mem_a[rd_a];
  assign head_b = mem_b[rd_b];

  always_ff @(posedge aclk) begin
    if (push_a && !clear) mem_a[wr_a] <= S_AXIS_A_tdata;
    if (push_b && !clear) mem_b[wr_b] <= S_AXIS_B_tdata;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_a  <= '0;
      rd_a  <= '0;
      cnt_a <= '0;
      wr_b  <= '0;
      rd_b  <= '0;
      cnt_b <= '0;
    end else if (clear) begin
      wr_a  <= '0;
      rd_a  <= '0;
      cnt_a <= '0;
      wr_b  <= '0;
      rd_b  <= '0;
      cnt_b <= '0;
    end else begin
      // Power-of-two depth lets the pointers wrap naturally.
      if (push_a) wr_a <= wr_a + AW'(1);
      if (push_b) wr_b <= wr_b + AW'(1);
      if (pop) begin
        rd_a <= rd_a + AW'(1);
        rd_b <= rd_b + AW'(1);
      end
      cnt_a <= cnt_a + CW'(push_a) - CW'(pop);
      cnt_b <= cnt_b + CW'(push_b) - CW'(pop);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      M_AXIS_tvalid <= 1'b0;
      M_AXIS_tdata  <= '0;
      skew_error    <= 1'b0;
    end else if (clear) begin
      M_AXIS_tvalid <= 1'b0;
      skew_error    <= 1'b0;
    end else begin
      if (pop) begin
        M_AXIS_tvalid <= 1'b1;
        M_AXIS_tdata  <= swap ? {head_a, head_b} : {head_b, head_a};
      end else if (M_AXIS_tready) begin
        M_AXIS_tvalid <= 1'b0;
      end
      if ((full_a && empty_b) || (full_b && empty_a)) skew_error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axis_channel_packer.sv
// tb/tb_axis_channel_packer.sv - scoreboard bench for axis_channel_packer
module tb_axis_channel_packer;
  localparam int W  = 32;
  localparam int HW = 16;

  logic          aclk = 1'b0;
  logic          aresetn, clear, swap;
  logic [HW-1:0] a_tdata, b_tdata;
  logic          a_tvalid, a_tready, b_tvalid, b_tready;
  logic          m_tready, m_tvalid, skew_error;
  logic [W-1:0]  m_tdata;

  int vectors     = 0;
  int miscompares = 0;
  int words_seen  = 0;
  bit sb_on       = 1'b0;
  logic [HW-1:0] sa[$];
  logic [HW-1:0] sb[$];
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  mon_exp;
  logic [HW-1:0] mon_a, mon_b;

  always #5 aclk = ~aclk;

  axis_channel_packer #(.AXIS_TDATA_WIDTH(W), .FIFO_DEPTH(4)) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .clear(clear),
    .swap(swap),
    .S_AXIS_A_tdata(a_tdata),
    .S_AXIS_A_tvalid(a_tvalid),
    .S_AXIS_A_tready(a_tready),
    .S_AXIS_B_tdata(b_tdata),
    .S_AXIS_B_tvalid(b_tvalid),
    .S_AXIS_B_tready(b_tready),
    .M_AXIS_tready(m_tready),
    .M_AXIS_tdata(m_tdata),
    .M_AXIS_tvalid(m_tvalid),
    .skew_error(skew_error)
  );

  // Handshakes seen here complete at the following rising edge.
  always @(negedge aclk) begin
    if (sb_on && aresetn) begin
      if (m_tvalid && m_tready) begin
        vectors++;
        words_seen++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected: got %h, required no word", m_tdata);
        end else begin
          mon_exp = exp_q.pop_front();
          if (m_tdata !== mon_exp) begin
            miscompares++;
            $display("FAIL sb_word: got %h, required %h", m_tdata, mon_exp);
          end
        end
      end
      if (!clear) begin
        if (a_tvalid && a_tready) sa.push_back(a_tdata);
        if (b_tvalid && b_tready) sb.push_back(b_tdata);
        while (sa.size() > 0 && sb.size() > 0) begin
          mon_a = sa.pop_front();
          mon_b = sb.pop_front();
          exp_q.push_back({mon_b, mon_a});
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic flush_model();
    exp_q.delete();
    sa.delete();
    sb.delete();
  endtask

  task automatic test_reset();
    aresetn = 1'b0; clear = 1'b0; swap = 1'b0; m_tready = 1'b0;
    a_tvalid = 1'b0; b_tvalid = 1'b0; a_tdata = '0; b_tdata = '0;
    tick(2);
    vectors++;
    if ({m_tvalid, skew_error, a_tready, b_tready} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, required 0000", {m_tvalid, skew_error, a_tready, b_tready});
    end
    vectors++;
    if (m_tdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_tdata: got %h, required 00000000", m_tdata);
    end
    aresetn = 1'b1;
    tick();
    vectors++;
    if ({a_tready, b_tready} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_ready: got %b, required 11", {a_tready, b_tready});
    end
  endtask

  task automatic test_basic(input logic sw, input logic [W-1:0] want);
    sb_on = 1'b0; swap = sw; m_tready = 1'b1;
    a_tdata = 16'h1111; b_tdata = 16'h2222; a_tvalid = 1'b1; b_tvalid = 1'b1;
    tick();
    a_tvalid = 1'b0; b_tvalid = 1'b0;
    vectors++;
    if (m_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_latency: got tvalid %b, required 0", m_tvalid);
    end
    tick();
    vectors++;
    if ({m_tvalid, m_tdata} !== {1'b1, want}) begin
      miscompares++;
      $display("FAIL basic_word: got %b/%h, required 1/%h", m_tvalid, m_tdata, want);
    end
    tick();
    vectors++;
    if (m_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_one_cycle: got tvalid %b, required 0", m_tvalid);
    end
  endtask

  task automatic test_swap_toggle();
    logic [HW-1:0] pa, pb;
    logic [W-1:0]  want;
    sb_on = 1'b0; m_tready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      a_tvalid = (i < 8); b_tvalid = (i < 8);
      a_tdata = 16'(32'h0A00 + i); b_tdata = 16'(32'h0B00 + i);
      swap = i[0];
      tick();
      if (i >= 1) begin
        pa = 16'(32'h0A00 + i - 1);
        pb = 16'(32'h0B00 + i - 1);
        want = i[0] ? {pa, pb} : {pb, pa};
        vectors++;
        if ({m_tvalid, m_tdata} !== {1'b1, want}) begin
          miscompares++;
          $display("FAIL swap_toggle[%0d]: got %b/%h, required 1/%h", i, m_tvalid, m_tdata, want);
        end
      end
    end
    a_tvalid = 1'b0; b_tvalid = 1'b0; swap = 1'b0;
    tick(2);
  endtask

  task automatic test_skew();
    int start;
    sb_on = 1'b1; m_tready = 1'b1; swap = 1'b0;
    start = words_seen;
    for (int i = 1; i <= 4; i++) begin
      a_tdata = 16'(i); a_tvalid = 1'b1;
      tick();
    end
    a_tvalid = 1'b0;
    vectors++;
    if ({a_tready, m_tvalid} !== 2'b00) begin
      miscompares++;
      $display("FAIL skew_full: got a_tready/tvalid %b, required 00", {a_tready, m_tvalid});
    end
    tick();
    vectors++;
    if (skew_error !== 1'b1) begin
      miscompares++;
      $display("FAIL skew_flag: got %b, required 1", skew_error);
    end
    for (int i = 1; i <= 4; i++) begin
      b_tdata = 16'(32'h0A00 + i); b_tvalid = 1'b1;
      tick();
    end
    b_tvalid = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) tick();
    tick(2);
    vectors++;
    if (words_seen - start !== 4) begin
      miscompares++;
      $display("FAIL skew_words: got %0d, required 4", words_seen - start);
    end
    vectors++;
    if (skew_error !== 1'b1) begin
      miscompares++;
      $display("FAIL skew_sticky: got %b, required 1", skew_error);
    end
  endtask

  task automatic test_backpressure();
    sb_on = 1'b1; m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_tdata = 16'(32'h3000 + i); b_tdata = 16'(32'h4000 + i);
      a_tvalid = 1'b1; b_tvalid = 1'b1;
      tick();
    end
    a_tvalid = 1'b0; b_tvalid = 1'b0;
    vectors++;
    if ({a_tready, b_tready} !== 2'b00) begin
      miscompares++;
      $display("FAIL bp_ready: got %b, required 00", {a_tready, b_tready});
    end
    vectors++;
    if ({m_tvalid, m_tdata} !== {1'b1, 32'h40003000}) begin
      miscompares++;
      $display("FAIL bp_head: got %b/%h, required 1/40003000", m_tvalid, m_tdata);
    end
    tick(3);
    vectors++;
    if ({m_tvalid, m_tdata} !== {1'b1, 32'h40003000}) begin
      miscompares++;
      $display("FAIL bp_stable: got %b/%h, required 1/40003000", m_tvalid, m_tdata);
    end
    m_tready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (m_tvalid !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_b2b[%0d]: got tvalid %b, required 1", k, m_tvalid);
      end
      tick();
    end
    vectors++;
    if ((m_tvalid !== 1'b0) || (exp_q.size() != 0)) begin
      miscompares++;
      $display("FAIL bp_drain: got tvalid %b pending %0d, required 0 and 0", m_tvalid, exp_q.size());
    end
  endtask

  task automatic test_clear();
    sb_on = 1'b1; m_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_tdata = 16'(32'h5000 + i); b_tdata = 16'(32'h6000 + i);
      a_tvalid = 1'b1; b_tvalid = 1'b1;
      tick();
    end
    b_tvalid = 1'b0;
    a_tdata = 16'hDEAD;
    clear = 1'b1;
    tick();
    clear = 1'b0; a_tvalid = 1'b0;
    flush_model();
    vectors++;
    if ({m_tvalid, a_tready, b_tready, skew_error} !== 4'b0110) begin
      miscompares++;
      $display("FAIL clear_state: got %b, required 0110", {m_tvalid, a_tready, b_tready, skew_error});
    end
    m_tready = 1'b1;
    a_tdata = 16'h1234; b_tdata = 16'h5678; a_tvalid = 1'b1; b_tvalid = 1'b1;
    tick();
    a_tvalid = 1'b0; b_tvalid = 1'b0;
    tick();
    vectors++;
    if ({m_tvalid, m_tdata} !== {1'b1, 32'h56781234}) begin
      miscompares++;
      $display("FAIL clear_next: got %b/%h, required 1/56781234", m_tvalid, m_tdata);
    end
    tick(2);
  endtask

  task automatic test_async_reset();
    sb_on = 1'b1; m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_tdata = 16'(32'h7000 + i); b_tdata = 16'(32'h8000 + i);
      a_tvalid = 1'b1; b_tvalid = 1'b1;
      tick();
    end
    a_tvalid = 1'b0; b_tvalid = 1'b0;
    #1 aresetn = 1'b0;
    #1;
    vectors++;
    if ({m_tvalid, skew_error, a_tready, b_tready} !== 4'b0000 || m_tdata !== 32'h0) begin
      miscompares++;
      $display("FAIL arst_outputs: got %b/%h, required 0000/00000000",
               {m_tvalid, skew_error, a_tready, b_tready}, m_tdata);
    end
    #1 aresetn = 1'b1;
    flush_model();
    tick();
    vectors++;
    if ({m_tvalid, a_tready, b_tready} !== 3'b011) begin
      miscompares++;
      $display("FAIL arst_release: got %b, required 011", {m_tvalid, a_tready, b_tready});
    end
  endtask

  task automatic test_random();
    int start;
    sb_on = 1'b1; swap = 1'b0;
    start = words_seen;
    for (int c = 0; c < 400; c++) begin
      a_tvalid = ($urandom_range(0, 3) != 0);
      b_tvalid = ($urandom_range(0, 3) != 0);
      a_tdata  = 16'($urandom);
      b_tdata  = 16'($urandom);
      m_tready = ($urandom_range(0, 3) != 0);
      tick();
    end
    a_tvalid = 1'b0; b_tvalid = 1'b0; m_tready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) tick();
    tick(2);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rand_drain: got %0d pending, required 0", exp_q.size());
    end
    vectors++;
    if (words_seen - start < 50) begin
      miscompares++;
      $display("FAIL rand_progress: got %0d words, required at least 50", words_seen - start);
    end
  endtask

  initial begin
    test_reset();
    test_basic(1'b0, 32'h22221111);
    test_basic(1'b1, 32'h11112222);
    test_swap_toggle();
    test_skew();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
